// File: rtl/glitc_intercom_tx_framer.sv
// glitc_intercom_tx_framer
//   Transmit-side framer for the GLITC intercom link. Payload words are queued
//   in a small FIFO and presented, one word per cycle, as a parallel word to a
//   bank of 4:1 lane serializers. A three-state link FSM (OFF/TRAIN/RUN)
//   selects between an all-ones idle level, a per-lane training nibble and
//   live payload. In RUN an empty FIFO produces an all-zero idle word (command
//   00) and bumps a saturating underrun counter.
//
// Ports
//   sysclk_i    in   1      single clock, rising edge
//   rst_n_i     in   1      asynchronous active-low reset
//   en_i        in   1      link enable (0 forces OFF from any state)
//   train_i     in   1      training request
//   data_i      in   W      payload word (W = 4*NBITS)
//   valid_i     in   1      data_i valid; accepted when ready_o=1
//   ready_o     out  1      FIFO can take a word (never in OFF)
//   oq_o        out  W      registered parallel word, lane i = [4i+3:4i]
//   oce_o       out  NBITS  registered per-lane serializer clock enable
//   state_o     out  2      00 OFF, 01 TRAIN, 10 RUN
//   underrun_o  out  8      saturating count of idle words emitted in RUN
//
// Build option
//   GLITC_INTERCOM_PARITY_EN : when defined, bit W-1 of every RUN word
//   (payload or idle) is replaced by the XOR of bits [W-2:0].
module glitc_intercom_tx_framer #(
  parameter int unsigned      NBITS         = 5,
  parameter int unsigned      FIFO_LOG2     = 2,
  parameter logic [NBITS-1:0] INVERT_MASK   = '0,
  parameter logic [3:0]       TRAIN_PATTERN = 4'b1010,
  parameter int unsigned      TRAIN_MIN     = 16
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 train_i,
  input  logic [4*NBITS-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [4*NBITS-1:0]   oq_o,
  output logic [NBITS-1:0]     oce_o,
  output logic [1:0]           state_o,
  output logic [7:0]           underrun_o
);

  localparam int unsigned W  = 4 * NBITS;
  localparam int unsigned CW = $clog2(TRAIN_MIN + 2);
  localparam logic [FIFO_LOG2:0] DEPTH_C = {1'b1, {FIFO_LOG2{1'b0}}};

  // Widen the per-lane inversion mask to one bit per output bit.
  function automatic logic [4*NBITS-1:0] expand_mask(input logic [NBITS-1:0] m);
    logic [4*NBITS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NBITS); i++) begin
      r[4*i +: 4] = {4{m[i]}};
    end
    return r;
  endfunction

  localparam logic [4*NBITS-1:0] INV_W   = expand_mask(INVERT_MASK);
  localparam logic [4*NBITS-1:0] TRAIN_W = {NBITS{TRAIN_PATTERN}};

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_TRAIN = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        train_cnt_q, train_cnt_d;
  logic [W-1:0]         oq_q, oq_d;
  logic [NBITS-1:0]     oce_q, oce_d;
  logic [7:0]           underrun_q, underrun_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   fifo_cnt_q, fifo_cnt_d;
  logic [W-1:0]         mem_q [2**FIFO_LOG2];

  logic                 push, pop, train_done;
  logic [W-1:0]         run_word, pre_word;

  assign ready_o    = (state_q != ST_OFF) && (fifo_cnt_q != DEPTH_C);
  assign push       = valid_i && ready_o;
  // Count includes the TRAIN cycle currently in progress.
  assign train_done = (32'(train_cnt_q) + 32'd1) >= TRAIN_MIN;

  always_comb begin
    state_d     = state_q;
    train_cnt_d = '0;
    case (state_q)
      ST_OFF: begin
        if (en_i) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!train_i && train_done) begin
          state_d = ST_RUN;
        end else if (32'(train_cnt_q) < TRAIN_MIN) begin
          train_cnt_d = train_cnt_q + CW'(1);
        end else begin
          train_cnt_d = train_cnt_q;
        end
      end
      ST_RUN: begin
        if (train_i) state_d = ST_TRAIN;
      end
      default: state_d = ST_OFF;
    endcase
    if (!en_i) begin
      state_d     = ST_OFF;
      train_cnt_d = '0;
    end

    // Outputs follow the next state so they change on the transition edge.
    pop      = (state_d == ST_RUN) && (fifo_cnt_q != '0);
    run_word = pop ? mem_q[rd_ptr_q] : '0;
`ifdef GLITC_INTERCOM_PARITY_EN
    run_word[W-1] = ^run_word[W-2:0];
`endif

    underrun_d = underrun_q;
    case (state_d)
      ST_TRAIN: begin
        pre_word = TRAIN_W;
        oce_d    = '1;
      end
      ST_RUN: begin
        pre_word = run_word;
        oce_d    = '1;
        if (!pop && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
      end
      default: begin
        pre_word = '1;
        oce_d    = '0;
      end
    endcase
    oq_d = pre_word ^ INV_W;

    // OFF flushes the queue; a word accepted on the edge into OFF is dropped.
    if (state_d == ST_OFF) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end else begin
      wr_ptr_d   = push ? wr_ptr_q + FIFO_LOG2'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + (FIFO_LOG2+1)'(push) - (FIFO_LOG2+1)'(pop);
    end
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_OFF;
      train_cnt_q <= '0;
      oq_q        <= {W{1'b1}} ^ INV_W;
      oce_q       <= '0;
      underrun_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      oq_q        <= oq_d;
      oce_q       <= oce_d;
      underrun_q  <= underrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge sysclk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign oq_o       = oq_q;
  assign oce_o      = oce_q;
  assign state_o    = state_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_glitc_intercom_tx_framer.sv
// Testbench for glitc_intercom_tx_framer. Two instances share all inputs:
// one with no lane inversion, one with lane 0 inverted. A queue-based model
// predicts outputs every cycle; directed literal checks pin the model.
module tb_glitc_intercom_tx_framer;

  localparam int DEPTH = 4;
  localparam int TMIN  = 16;
  localparam logic [19:0] INV_W = 20'h0000F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, train = 1'b0, valid = 1'b0;
  logic [19:0] data = '0;

  logic        ready, ready_x;
  logic [19:0] oq, oq_x;
  logic [4:0]  oce, oce_x;
  logic [1:0]  st, st_x;
  logic [7:0]  und, und_x;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  glitc_intercom_tx_framer #(.NBITS(5), .FIFO_LOG2(2), .INVERT_MASK(5'b00000),
                             .TRAIN_PATTERN(4'b1010), .TRAIN_MIN(TMIN)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .en_i(en), .train_i(train),
    .data_i(data), .valid_i(valid), .ready_o(ready), .oq_o(oq),
    .oce_o(oce), .state_o(st), .underrun_o(und));

  glitc_intercom_tx_framer #(.NBITS(5), .FIFO_LOG2(2), .INVERT_MASK(5'b00001),
                             .TRAIN_PATTERN(4'b1010), .TRAIN_MIN(TMIN)) dut_x (
    .sysclk_i(clk), .rst_n_i(rst_n), .en_i(en), .train_i(train),
    .data_i(data), .valid_i(valid), .ready_o(ready_x), .oq_o(oq_x),
    .oce_o(oce_x), .state_o(st_x), .underrun_o(und_x));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_state: 0 OFF, 1 TRAIN, 2 RUN. m_tc = TRAIN cycles elapsed so far.
  int          m_state = 0;
  int          m_tc = 0;
  int          m_under = 0;
  logic [19:0] m_q[$];
  logic [19:0] m_oq = 20'hFFFFF;
  logic [4:0]  m_oce = 5'h00;
  bit          m_acc;
  int          m_ns;
  logic [19:0] m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_tc = 0; m_under = 0; m_q.delete();
      m_oq = 20'hFFFFF; m_oce = 5'h00;
    end else begin
      m_acc = valid && (m_state != 0) && (m_q.size() < DEPTH);
      if (m_state == 1) m_tc++;
      m_ns = m_state;
      if (m_state == 0 && en) m_ns = 1;
      if (m_state == 1 && !train && m_tc >= TMIN) m_ns = 2;
      if (m_state == 2 && train) m_ns = 1;
      if (!en) m_ns = 0;
      if (m_ns != 1 || m_state != 1) m_tc = 0;
      if (m_ns == 0) begin
        m_q.delete();
        m_oq = 20'hFFFFF; m_oce = 5'h00;
      end else if (m_ns == 1) begin
        if (m_acc) m_q.push_back(data);
        m_oq = 20'hAAAAA; m_oce = 5'h1F;
      end else begin
        if (m_q.size() > 0) m_w = m_q.pop_front();
        else begin
          m_w = '0;
          if (m_under < 255) m_under++;
        end
`ifdef GLITC_INTERCOM_PARITY_EN
        m_w[19] = ^m_w[18:0];
`endif
        if (m_acc) m_q.push_back(data);
        m_oq = m_w; m_oce = 5'h1F;
      end
      m_state = m_ns;
    end
  end

  always @(negedge clk) begin
    chk("cmp_state",   32'(st),      32'(m_state));
    chk("cmp_state_x", 32'(st_x),    32'(m_state));
    chk("cmp_oq",      32'(oq),      32'(m_oq));
    chk("cmp_oq_x",    32'(oq_x),    32'(m_oq ^ INV_W));
    chk("cmp_oce",     32'(oce),     32'(m_oce));
    chk("cmp_oce_x",   32'(oce_x),   32'(m_oce));
    chk("cmp_ready",   32'(ready),   32'(m_state != 0 && m_q.size() < DEPTH));
    chk("cmp_ready_x", 32'(ready_x), 32'(m_state != 0 && m_q.size() < DEPTH));
    chk("cmp_under",   32'(und),     32'(m_under));
    chk("cmp_under_x", 32'(und_x),   32'(m_under));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (st == 2'd2) break;
    end
    chk(name, 32'(st), 32'd2);
  endtask

  logic [19:0] lat_exp, par_exp;
  logic [19:0] bp_word [5];
  logic [19:0] bp_exp  [5];
  int          n_train;
  int          u0;

  initial begin
    bp_word[0] = 20'h11111; bp_word[1] = 20'h22222; bp_word[2] = 20'h33333;
    bp_word[3] = 20'h44444; bp_word[4] = 20'h55555;
`ifdef GLITC_INTERCOM_PARITY_EN
    lat_exp = 20'hB5ABC; par_exp = 20'h80001;
    bp_exp[0] = 20'h91111; bp_exp[1] = 20'hA2222; bp_exp[2] = 20'h33333;
    bp_exp[3] = 20'hC4444; bp_exp[4] = 20'h00000;
`else
    lat_exp = 20'h35ABC; par_exp = 20'h00001;
    bp_exp[0] = 20'h11111; bp_exp[1] = 20'h22222; bp_exp[2] = 20'h33333;
    bp_exp[3] = 20'h44444; bp_exp[4] = 20'h00000;
`endif

    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_oq", 32'(oq), 32'h000FFFFF);
    chk("rst_oq_inv", 32'(oq_x), 32'h000FFFF0);
    chk("rst_oce", 32'(oce_x), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_under", 32'(und), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("off_hold", 32'(st), 32'd0);

    // Training length and pattern.
    en = 1'b1; train = 1'b0;
    n_train = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (st == 2'd1) begin
        if (n_train == 0) begin
          chk("train_oq", 32'(oq), 32'h000AAAAA);
          chk("train_oq_inv", 32'(oq_x), 32'h000AAAA5);
          chk("train_oce", 32'(oce), 32'h1F);
        end
        n_train++;
      end else if (st != 2'd0) begin
        break;
      end
    end
    chk("train_len", 32'(n_train), 32'd16);
    chk("train_to_run", 32'(st), 32'd2);
    chk("run_idle_oq", 32'(oq), 32'd0);
    chk("run_under1", 32'(und), 32'd1);

    // Latency from acceptance.
    data = 20'h35ABC; valid = 1'b1;
    cyc(1);
    valid = 1'b0; data = '0;
    chk("lat_edge1_idle", 32'(oq), 32'd0);
    cyc(1);
    chk("lat_edge2", 32'(oq), 32'(lat_exp));
    cyc(1);
    chk("lat_after_idle", 32'(oq), 32'd0);
    u0 = int'(und);
    cyc(3);
    chk("under_inc", 32'(und), 32'(u0 + 3));

    // Parity bit on a payload word and on idle.
    data = 20'h00001; valid = 1'b1;
    cyc(1);
    valid = 1'b0; data = '0;
    cyc(1);
    chk("par_word", 32'(oq), 32'(par_exp));
    cyc(1);
    chk("par_idle", 32'(oq), 32'd0);

    // Backpressure while held in TRAIN.
    train = 1'b1;
    cyc(1);
    chk("bp_train", 32'(st), 32'd1);
    chk("bp_train_oq", 32'(oq), 32'h000AAAAA);
    for (int k = 0; k < 5; k++) begin
      data = bp_word[k]; valid = 1'b1;
      chk($sformatf("bp_ready%0d", k), 32'(ready), (k < 4) ? 32'd1 : 32'd0);
      cyc(1);
    end
    valid = 1'b0; data = '0;
    cyc(20);
    u0 = int'(und);
    train = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk($sformatf("bp_out%0d", k), 32'(oq), 32'(bp_exp[k]));
      chk($sformatf("bp_run%0d", k), 32'(st), 32'd2);
    end
    chk("bp_under", 32'(und), 32'(u0 + 1));

    // Disable during RUN with three words still queued.
    train = 1'b1;
    cyc(1);
    data = 20'h00003; valid = 1'b1; cyc(1);
    data = 20'h00005; cyc(1);
    data = 20'h00006; cyc(1);
    data = 20'h00009; cyc(1);
    valid = 1'b0; data = '0;
    cyc(18);
    train = 1'b0;
    cyc(1);
    chk("dis_first", 32'(oq), 32'h3);
    en = 1'b0;
    cyc(1);
    chk("dis_state", 32'(st), 32'd0);
    chk("dis_oq", 32'(oq), 32'h000FFFFF);
    chk("dis_oq_inv", 32'(oq_x), 32'h000FFFF0);
    chk("dis_ready", 32'(ready), 32'd0);
    en = 1'b1;
    wait_run("dis_rerun");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dis_idle%0d", k), 32'(oq), 32'd0);
      cyc(1);
    end

    // Asynchronous reset mid-RUN with a word just accepted.
    data = 20'h00007; valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st_x), 32'd0);
    chk("arst_oq_inv", 32'(oq_x), 32'h000FFFF0);
    chk("arst_oce", 32'(oce_x), 32'd0);
    chk("arst_under", 32'(und), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    valid = 1'b0; data = '0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("arst_train", 32'(st), 32'd1);
    wait_run("arst_rerun");
    chk("arst_no_stale", 32'(oq), 32'd0);
    chk("arst_under1", 32'(und), 32'd1);
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glitc_intercom_tx_framer.md
GLITC_INTERCOM_TX_FRAMER -- requirements
Module: glitc_intercom_tx_framer

Interface
REQ-001 SHALL have parameter NBITS, default 5, number of serial lanes; word width W = 4*NBITS.
REQ-002 SHALL have parameter FIFO_LOG2, default 2, FIFO depth = 2**FIFO_LOG2 words.
REQ-003 SHALL have parameter INVERT_MASK, default 0, NBITS bits; bit i set inverts all 4 bits of lane i.
REQ-004 SHALL have parameter TRAIN_PATTERN, default 4'b1010, 4-bit per-lane training nibble.
REQ-005 SHALL have parameter TRAIN_MIN, default 16, minimum TRAIN cycles before RUN.
REQ-006 SHALL have port sysclk_i  input  1  the only clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en_i  input  1  link enable.
REQ-009 SHALL have port train_i  input  1  training request.
REQ-010 SHALL have port data_i  input  W  payload: [11:0] power, [17:12] corr, [19:18] command at NBITS=5.
REQ-011 SHALL have port valid_i  input  1  data_i valid.
REQ-012 SHALL have port ready_o  output  1  FIFO not full.
REQ-013 SHALL have port oq_o  output  W  registered parallel word for the serializers; lane i = bits [4i+3:4i], bit 4i+3 sent first.
REQ-014 SHALL have port oce_o  output  NBITS  registered per-lane serializer clock enable.
REQ-015 SHALL have port state_o  output  2  00 OFF, 01 TRAIN, 10 RUN.
REQ-016 SHALL have port underrun_o  output  8  saturating count of RUN cycles with an empty FIFO.

Function
REQ-017 SHALL accept a word on an edge where valid_i=1 and ready_o=1; ready_o SHALL be 0 when FIFO holds 2**FIFO_LOG2 words.
REQ-018 SHALL, with valid_i=1 on a full FIFO, ignore the word; simultaneous push and pop on a full FIFO SHALL not occur since ready_o=0.
REQ-019 SHALL implement FSM OFF -> TRAIN when en_i=1; TRAIN -> RUN when train_i=0 and TRAIN cycle count >= TRAIN_MIN; RUN -> TRAIN when train_i=1 (count restarts at 0); any state -> OFF when en_i=0 (highest priority).
REQ-020 SHALL flush the FIFO and hold ready_o=0 while in OFF; FIFO SHALL accept words in TRAIN and RUN.
REQ-021 SHALL in OFF drive oq_o = all ones before inversion and oce_o = 0.
REQ-022 SHALL in TRAIN drive TRAIN_PATTERN on every lane each cycle, no FIFO pop, oce_o = all ones.
REQ-023 SHALL in RUN pop one word per cycle when non-empty and drive it on oq_o the next edge; when empty drive all zeros (command 00 = idle) and increment underrun_o, saturating at 255.
REQ-024 SHALL give latency of exactly 2 sysclk_i edges from acceptance to oq_o when in RUN with FIFO empty.
REQ-025 SHALL apply INVERT_MASK as the last operation on oq_o in every state.
REQ-026 SHALL change oq_o, oce_o and state_o on the same edge as the FSM transition they reflect.
REQ-027 SHALL clear underrun_o only on reset.

Reset
REQ-028 SHALL on rst_n_i=0, asynchronously: state OFF, FIFO empty, ready_o=0, oq_o = INVERT_MASK-applied all ones, oce_o=0, underrun_o=0, TRAIN count 0.
REQ-029 SHALL release reset synchronously; first transition evaluated on the first edge after rst_n_i rises.
REQ-030 SHALL discard FIFO contents on reset mid-operation; no partial word output.

Configuration
REQ-031 SHALL, when macro GLITC_INTERCOM_PARITY_EN is defined, replace bit W-1 of each RUN-state word (popped or idle) with XOR of bits [W-2:0], before inversion.
REQ-032 SHALL, without GLITC_INTERCOM_PARITY_EN, pass bit W-1 unchanged; OFF and TRAIN output unaffected either way.

Verification
REQ-033 SHALL test reset: rst_n_i=0 mid-RUN, INVERT_MASK=5'b00001 -> oq_o=20'hFFFF0, oce_o=0, state_o=00 immediately.
REQ-034 SHALL test training: en_i=1, train_i=0 -> state_o=01 for exactly 16 cycles, oq_o=20'hAAAAA, then 10.
REQ-035 SHALL test latency: RUN, empty FIFO, push 20'h3_5ABC -> oq_o=20'h35ABC exactly 2 edges later (parity off).
REQ-036 SHALL test backpressure: RUN held in TRAIN, push 5 words -> ready_o=0 after 4; 5th dropped; RUN outputs words 1-4 in order, then idle with underrun_o incrementing.
REQ-037 SHALL test parity: GLITC_INTERCOM_PARITY_EN defined, push 20'h00001 -> oq_o=20'h80001; idle word -> 20'h00000.
REQ-038 SHALL test en_i=0 during RUN with 3 queued words -> OFF next edge, FIFO empty, words not emitted after re-enable.
